tcpc_reg_master: RTL and testbench

Initiator side of the TCPC register-access handshake. Takes single-byte write or burst-read commands from the port-manager logic and drives ADDR/RNW/WR_DATA/req toward the TCPC register file, waits for ACK, and returns read bytes as response pulses. It sits between the policy/alert-handling logic and the register bank. Its typical job is draining RX_BUF_* after RECEIVE_BYTE_COUNT is known.

---
 rtl/tcpc_reg_master_if.sv | 37 +++
 rtl/tcpc_reg_master.sv | 174 +++++++++++++++++
 tb/tb_tcpc_reg_master.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcpc_reg_master_if.sv
// Command, register-bank and response signals of the TCPC register-access initiator.
// master = tcpc_reg_master view; slave = port-manager / register-bank view.
interface tcpc_reg_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rnw;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [3:0] cmd_len;

    logic [7:0] ADDR;
    logic       RNW;
    logic [7:0] WR_DATA;
    logic [7:0] RD_DATA;
    logic       req;
    logic       ACK;

    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       rsp_err;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_len,
        input  RD_DATA, ACK,
        output cmd_ready, ADDR, RNW, WR_DATA, req,
        output rsp_valid, rsp_data, rsp_last, rsp_err, busy
    );

    modport slave (
        output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_len,
        output RD_DATA, ACK,
        input  cmd_ready, ADDR, RNW, WR_DATA, req,
        input  rsp_valid, rsp_data, rsp_last, rsp_err, busy
    );
endinterface

// File: rtl/tcpc_reg_master.sv
module tcpc_reg_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rnw,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic [3:0] cmd_len,
  output logic [7:0] ADDR,
  output logic       RNW,
  output logic [7:0] WR_DATA,
  input  logic [7:0] RD_DATA,
  output logic       req,
  input  logic       ACK,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_addr;
  logic       r_rnw;
  logic [7:0] r_wdata;
  logic [3:0] r_count;

  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_rsp_last;

  logic       w_accept;
  logic       w_capture;
  logic       w_advance;
  logic       w_abort;
  logic       w_tmo_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_advance   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (ACK) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (w_tmo_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!ACK) begin
          if (r_count == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end else if (w_tmo_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_rnw   <= 1'b1;
      r_wdata <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_addr  <= cmd_addr;
      r_rnw   <= cmd_rnw;
      r_wdata <= cmd_wdata;
      r_count <= cmd_rnw ? cmd_len : 4'd0;
    end else if (w_advance) begin
      r_addr  <= r_addr + 8'd1;
      r_count <= r_count - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_rsp_valid <= w_capture | w_abort;
      if (w_capture) begin
        r_rsp_data <= r_rnw ? RD_DATA : 8'h00;
        r_rsp_last <= (r_count == '0);
      end else if (w_abort) begin
        r_rsp_data <= '0;
        r_rsp_last <= 1'b1;
      end
    end
  end

`ifdef TCPC_REG_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] r_tmo;
  logic          r_rsp_err;

  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmo <= '0;
    end else if (r_state != S_IDLE) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_abort;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_tmo_hit = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign req       = (r_state == S_REQ);
  assign ADDR      = r_addr;
  assign RNW       = r_rnw;
  assign WR_DATA   = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_tcpc_reg_master.sv
// Randomized bench for tcpc_reg_master: a behavioural register bank answers req/ACK and a
// command-level model predicts every access and response byte.
module tb_tcpc_reg_master;

    logic clk;
    logic reset;

    tcpc_reg_master_if bus();

    tcpc_reg_master #(.TIMEOUT_CYCLES(10)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (bus.cmd_valid),
        .cmd_ready (bus.cmd_ready),
        .cmd_rnw   (bus.cmd_rnw),
        .cmd_addr  (bus.cmd_addr),
        .cmd_wdata (bus.cmd_wdata),
        .cmd_len   (bus.cmd_len),
        .ADDR      (bus.ADDR),
        .RNW       (bus.RNW),
        .WR_DATA   (bus.WR_DATA),
        .RD_DATA   (bus.RD_DATA),
        .req       (bus.req),
        .ACK       (bus.ACK),
        .rsp_valid (bus.rsp_valid),
        .rsp_data  (bus.rsp_data),
        .rsp_last  (bus.rsp_last),
        .rsp_err   (bus.rsp_err),
        .busy      (bus.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    logic [7:0]  mem [256];
    logic [16:0] exp_acc [$];
    logic [9:0]  exp_rsp [$];

    // bank knobs and state
    int          bank_st;
    int          bank_dly;
    int          bank_hold;
    bit          bank_en;
    int          fixed_dly;
    int          fixed_hold;

    logic        prev_req;
    logic        hs_prev;
    logic [16:0] cur_acc;
    int unsigned rsp_seen;
    int unsigned req_rises;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Command-level reference: one access per byte, address wrapping at 256.
    task automatic issue_cmd(input logic rnw, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [3:0] len, input bit tmo);
        int unsigned w;
        int unsigned n;
        logic [7:0]  a;
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = rnw;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_len   = len;
        w = 0;
        while (!bus.cmd_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_accept_timeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        n = rnw ? int'(len) : 0;
        if (tmo) begin
            exp_acc.push_back({addr, rnw, wdata});
            exp_rsp.push_back({8'h00, 1'b1, 1'b1});
        end else begin
            for (int i = 0; i <= int'(n); i++) begin
                a = addr + 8'(i);
                exp_acc.push_back({a, rnw, wdata});
                exp_rsp.push_back({rnw ? mem[a] : 8'h00, (i == int'(n)), 1'b0});
            end
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("req_after_accept", 32'(bus.req), 32'd1);
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_idle();
        int unsigned w;
        w = 0;
        while ((exp_rsp.size() != 0 || bus.busy) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(exp_rsp.size()), 32'd0);
        chk("drain_busy", 32'(bus.busy), 32'd0);
        chk("drain_acc", 32'(exp_acc.size()), 32'd0);
    endtask

    // Monitor first (values as seen at the last rising edge), then the bank drives for the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req    = 1'b0;
                hs_prev     = 1'b0;
                bus.ACK     = 1'b0;
                bank_st     = 0;
                continue;
            end
            if (bus.req && !prev_req) begin
                req_rises++;
                chk("req_rise_ack_low", 32'(bus.ACK), 32'd0);
                if (exp_acc.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    chk("access", 32'({bus.ADDR, bus.RNW, bus.WR_DATA}), 32'(exp_acc.pop_front()));
                end
                cur_acc = {bus.ADDR, bus.RNW, bus.WR_DATA};
            end else if (bus.req) begin
                chk("access_stable", 32'({bus.ADDR, bus.RNW, bus.WR_DATA}), 32'(cur_acc));
            end
            if (hs_prev) begin
                chk("req_drop", 32'(bus.req), 32'd0);
            end
            if (bus.rsp_valid || (prev_req && !bus.req)) begin
                chk("rsp_pulse", 32'(bus.rsp_valid), 32'(prev_req && !bus.req));
            end
            if (bus.rsp_valid) begin
                rsp_seen++;
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("rsp", 32'({bus.rsp_data, bus.rsp_last, bus.rsp_err}), 32'(exp_rsp.pop_front()));
                end
            end
            prev_req = bus.req;

            case (bank_st)
                0: begin
                    if (bus.req && bank_en) begin
                        bank_dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                        bank_st  = 1;
                    end
                end
                2: begin
                    bank_hold--;
                    if (bank_hold <= 0) begin
                        bus.ACK     = 1'b0;
                        bus.RD_DATA = 8'($urandom);
                        bank_st     = 0;
                    end
                end
                default: ;
            endcase
            if (bank_st == 1) begin
                if (bank_dly == 0) begin
                    bus.ACK     = 1'b1;
                    bus.RD_DATA = mem[bus.ADDR];
                    bank_hold   = (fixed_hold > 0) ? fixed_hold : int'($urandom_range(1, 5));
                    bank_st     = 2;
                end else begin
                    bank_dly--;
                end
            end
            hs_prev = bus.req && bus.ACK;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned saved_rsp;
        int unsigned saved_rise;
        int unsigned base;
        int unsigned w;
        int unsigned n;

        n_checks   = 0;
        n_fail     = 0;
        rsp_seen   = 0;
        req_rises  = 0;
        bank_st    = 0;
        bank_en    = 1'b1;
        fixed_dly  = -1;
        fixed_hold = -1;
        prev_req   = 1'b0;
        hs_prev    = 1'b0;
        cur_acc    = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rnw   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_len   = '0;
        bus.ACK       = 1'b0;
        bus.RD_DATA   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_addr", 32'(bus.ADDR), 32'h00);
        chk("rst_rnw", 32'(bus.RNW), 32'd1);
        chk("rst_wdata", 32'(bus.WR_DATA), 32'h00);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_last, bus.rsp_err}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);

        // single write, ACK two cycles after req
        fixed_dly = 2;
        issue_cmd(1'b0, 8'h1A, 8'h5C, 4'd9, 1'b0);
        wait_idle();
        fixed_dly = -1;

        // burst read of four from 8'h31
        for (int i = 0; i < 4; i++) mem[8'h31 + i] = 8'hA0 + 8'(i);
        issue_cmd(1'b1, 8'h31, 8'h00, 4'd3, 1'b0);
        wait_idle();

        // address wrap
        issue_cmd(1'b1, 8'hFF, 8'h00, 4'd1, 1'b0);
        wait_idle();
        chk("idle_holds_addr", 32'(bus.ADDR), 32'h00);

        // slow ACK release
        fixed_hold = 5;
        base = req_rises;
        issue_cmd(1'b1, 8'($urandom), 8'h00, 4'd1, 1'b0);
        wait_idle();
        chk("slow_ack_reqs", 32'(req_rises - base), 32'd2);
        fixed_hold = -1;

        // randomized commands, sometimes back-to-back
        for (int c = 0; c < 40; c++) begin
            issue_cmd(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom),
                      8'($urandom), 4'($urandom), 1'b0);
            n = $urandom_range(0, 3);
            for (int g = 0; g < int'(n); g++) @(negedge clk);
        end
        wait_idle();

        // reset during the 3rd byte of an 8-byte burst
        base = rsp_seen;
        issue_cmd(1'b1, 8'h80, 8'($urandom), 4'd7, 1'b0);
        w = 0;
        while (!(bus.req && (rsp_seen - base) == 2) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("third_byte_reached", 32'(rsp_seen - base), 32'd2);
        bus.cmd_valid = 1'b1;
        bus.cmd_rnw   = 1'b1;
        bus.cmd_addr  = 8'h55;
        bus.cmd_len   = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_req", 32'(bus.req), 32'd0);
        chk("midrst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midrst_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        reset = 1'b0;
        exp_acc.delete();
        exp_rsp.delete();
        saved_rsp  = rsp_seen;
        saved_rise = req_rises;
        repeat (20) @(negedge clk);
        chk("no_rsp_after_reset", 32'(rsp_seen), 32'(saved_rsp));
        chk("no_req_after_reset", 32'(req_rises), 32'(saved_rise));
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // recovery after reset
        issue_cmd(1'b1, 8'($urandom), 8'h00, 4'd2, 1'b0);
        wait_idle();

`ifdef TCPC_REG_TIMEOUT_EN
        bank_en = 1'b0;
        issue_cmd(1'b1, 8'($urandom), 8'h00, 4'd3, 1'b1);
        n = 0;
        while (bus.req && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_req_cycles", 32'(n), 32'd10);
        chk("tmo_rsp_flags", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_last}), 32'b111);
        chk("tmo_busy", 32'(bus.busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("tmo_no_more", 32'(exp_rsp.size()), 32'd0);
        bank_en = 1'b1;
        issue_cmd(1'b0, 8'h10, 8'h77, 4'd0, 1'b0);
        wait_idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
